// File: rtl/ceyloniac_mem_pkg.sv
// Shared encodings and default widths for the ceyloniac RAM arbiter.
package ceyloniac_mem_pkg;

  localparam int unsigned RAM_DATA_WIDTH_DEF = 32;
  localparam int unsigned RAM_ADDR_WIDTH_DEF = 16;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } arb_state_e;

  localparam logic REQ_FETCH = 1'b0;
  localparam logic REQ_DATA  = 1'b1;

endpackage

// File: rtl/ceyloniac_rr_arb2.sv
// Two-way round-robin grant; remembers the last winner so ties alternate.
module ceyloniac_rr_arb2
  import ceyloniac_mem_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic req0,
  input  logic req1,
  output logic gnt_valid_c,
  output logic gnt_id_c
);

  logic last_grant_q, last_grant_d;

  // Every valid grant is taken by the sequencer, so history advances on any grant.
  always_comb begin
    gnt_valid_c  = req0 | req1;
    gnt_id_c     = REQ_FETCH;
    last_grant_d = last_grant_q;
    if (req0 && req1) begin
      gnt_id_c = ~last_grant_q;
    end else if (req1) begin
      gnt_id_c = REQ_DATA;
    end
    if (gnt_valid_c) begin
      last_grant_d = gnt_id_c;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant_q <= REQ_DATA;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/ceyloniac_ram_arbiter.sv
// Shares one single-port RAM between fetch and data requesters: one-cycle
// registered ACCESS per grant, read capture and one-cycle ack on its closing edge.
module ceyloniac_ram_arbiter
  import ceyloniac_mem_pkg::*;
#(
  parameter int unsigned RAM_DATA_WIDTH = RAM_DATA_WIDTH_DEF,
  parameter int unsigned RAM_ADDR_WIDTH = RAM_ADDR_WIDTH_DEF
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      req0,
  input  logic [RAM_ADDR_WIDTH-1:0] addr0,
  input  logic                      we0,
  input  logic [RAM_DATA_WIDTH-1:0] wdata0,
  output logic                      ack0,
  output logic [RAM_DATA_WIDTH-1:0] rdata0,
  input  logic                      req1,
  input  logic [RAM_ADDR_WIDTH-1:0] addr1,
  input  logic                      we1,
  input  logic [RAM_DATA_WIDTH-1:0] wdata1,
  output logic                      ack1,
  output logic [RAM_DATA_WIDTH-1:0] rdata1,
  output logic                      ram_enable,
  output logic                      ram_read_enable,
  output logic                      ram_write_enable,
  output logic [RAM_ADDR_WIDTH-1:0] ram_addr,
  output logic [RAM_DATA_WIDTH-1:0] ram_write_data,
  input  logic [RAM_DATA_WIDTH-1:0] ram_read_data
);

  arb_state_e                state_q, state_d;
  logic                      served_q, served_d;
  logic                      ram_enable_q, ram_enable_d;
  logic                      ram_read_enable_q, ram_read_enable_d;
  logic                      ram_write_enable_q, ram_write_enable_d;
  logic [RAM_ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [RAM_DATA_WIDTH-1:0] ram_write_data_q, ram_write_data_d;
  logic                      ack0_q, ack0_d;
  logic                      ack1_q, ack1_d;
  logic [RAM_DATA_WIDTH-1:0] rdata0_q, rdata0_d;
  logic [RAM_DATA_WIDTH-1:0] rdata1_q, rdata1_d;

  logic req0_elig_c, req1_elig_c;
  logic gnt_valid_c, gnt_id_c;

  // The port in service still holds req until it sees its ack; keep it out of arbitration.
  assign req0_elig_c = req0 & ~((state_q == ST_ACCESS) & (served_q == REQ_FETCH));
  assign req1_elig_c = req1 & ~((state_q == ST_ACCESS) & (served_q == REQ_DATA));

  ceyloniac_rr_arb2 u_arb (
    .clk         (clk),
    .reset_n     (reset_n),
    .req0        (req0_elig_c),
    .req1        (req1_elig_c),
    .gnt_valid_c (gnt_valid_c),
    .gnt_id_c    (gnt_id_c)
  );

  always_comb begin
    state_d            = state_q;
    served_d           = served_q;
    ram_enable_d       = 1'b0;
    ram_read_enable_d  = 1'b0;
    ram_write_enable_d = 1'b0;
    ram_addr_d         = ram_addr_q;
    ram_write_data_d   = ram_write_data_q;
    ack0_d             = 1'b0;
    ack1_d             = 1'b0;
    rdata0_d           = rdata0_q;
    rdata1_d           = rdata1_q;

    // Close the access in flight: ack the served port, capture read data.
    if (state_q == ST_ACCESS) begin
      if (served_q == REQ_FETCH) begin
        ack0_d = 1'b1;
        if (ram_read_enable_q) begin
          rdata0_d = ram_read_data;
        end
      end else begin
        ack1_d = 1'b1;
        if (ram_read_enable_q) begin
          rdata1_d = ram_read_data;
        end
      end
    end

    if (gnt_valid_c) begin
      state_d      = ST_ACCESS;
      served_d     = gnt_id_c;
      ram_enable_d = 1'b1;
      if (gnt_id_c == REQ_DATA) begin
        ram_addr_d         = addr1;
        ram_write_data_d   = wdata1;
        ram_write_enable_d = we1;
        ram_read_enable_d  = ~we1;
      end else begin
        ram_addr_d         = addr0;
        ram_write_data_d   = wdata0;
        ram_write_enable_d = we0;
        ram_read_enable_d  = ~we0;
      end
    end else begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q            <= ST_IDLE;
      served_q           <= REQ_FETCH;
      ram_enable_q       <= 1'b0;
      ram_read_enable_q  <= 1'b0;
      ram_write_enable_q <= 1'b0;
      ram_addr_q         <= '0;
      ram_write_data_q   <= '0;
      ack0_q             <= 1'b0;
      ack1_q             <= 1'b0;
      rdata0_q           <= '0;
      rdata1_q           <= '0;
    end else begin
      state_q            <= state_d;
      served_q           <= served_d;
      ram_enable_q       <= ram_enable_d;
      ram_read_enable_q  <= ram_read_enable_d;
      ram_write_enable_q <= ram_write_enable_d;
      ram_addr_q         <= ram_addr_d;
      ram_write_data_q   <= ram_write_data_d;
      ack0_q             <= ack0_d;
      ack1_q             <= ack1_d;
      rdata0_q           <= rdata0_d;
      rdata1_q           <= rdata1_d;
    end
  end

  assign ack0             = ack0_q;
  assign ack1             = ack1_q;
  assign rdata0           = rdata0_q;
  assign rdata1           = rdata1_q;
  assign ram_enable       = ram_enable_q;
  assign ram_read_enable  = ram_read_enable_q;
  assign ram_write_enable = ram_write_enable_q;
  assign ram_addr         = ram_addr_q;
  assign ram_write_data   = ram_write_data_q;

endmodule

// File: tb/tb_ceyloniac_ram_arbiter.sv
// Bench for ceyloniac_ram_arbiter: directed vector table, reset/race sequences,
// then random two-requester traffic scored against a transaction-level memory model.
module tb_ceyloniac_ram_arbiter;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 16;

  logic          clk;
  logic          reset_n;
  logic          req   [2];
  logic          we    [2];
  logic [AW-1:0] addr  [2];
  logic [DW-1:0] wdata [2];
  logic          ack0, ack1;
  logic [DW-1:0] rdata0, rdata1;
  logic          ram_enable, ram_read_enable, ram_write_enable;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_write_data, ram_read_data;

  logic [DW-1:0] ram_mem [256];
  logic [DW-1:0] ref_mem [int];
  int            n_pass, n_total, cyc;

  typedef struct {
    logic          r0, w0; logic [AW-1:0] a0; logic [DW-1:0] d0;
    logic          r1, w1; logic [AW-1:0] a1; logic [DW-1:0] d1;
    logic          en, re, wr; logic [AW-1:0] ad;
    logic          k0, k1; logic [DW-1:0] q0, q1;
  } vec_t;
  vec_t vecs[$];

  ceyloniac_ram_arbiter dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .req0             (req[0]),
    .addr0            (addr[0]),
    .we0              (we[0]),
    .wdata0           (wdata[0]),
    .ack0             (ack0),
    .rdata0           (rdata0),
    .req1             (req[1]),
    .addr1            (addr[1]),
    .we1              (we[1]),
    .wdata1           (wdata[1]),
    .ack1             (ack1),
    .rdata1           (rdata1),
    .ram_enable       (ram_enable),
    .ram_read_enable  (ram_read_enable),
    .ram_write_enable (ram_write_enable),
    .ram_addr         (ram_addr),
    .ram_write_data   (ram_write_data),
    .ram_read_data    (ram_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural single-port RAM: synchronous write, combinational read.
  assign ram_read_data = ram_enable ? ram_mem[ram_addr[7:0]] : 32'h0;
  initial begin
    for (int i = 0; i < 256; i++) ram_mem[i] = 32'h0;
    forever begin
      @(posedge clk);
      if (ram_enable && ram_write_enable) ram_mem[ram_addr[7:0]] = ram_write_data;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_total);
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic vec_t mk(
    input logic r0, input logic w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
    input logic r1, input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
    input logic en, input logic re, input logic wr, input logic [AW-1:0] ad,
    input logic k0, input logic k1, input logic [DW-1:0] q0, input logic [DW-1:0] q1);
    vec_t v;
    v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
    v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
    v.en = en; v.re = re; v.wr = wr; v.ad = ad;
    v.k0 = k0; v.k1 = k1; v.q0 = q0; v.q1 = q1;
    return v;
  endfunction

  task automatic clear_inputs();
    for (int p = 0; p < 2; p++) begin
      req[p] = 1'b0; we[p] = 1'b0; addr[p] = '0; wdata[p] = '0;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_en"}, 32'(ram_enable), 32'd0);
    chk({tag, "_re"}, 32'(ram_read_enable), 32'd0);
    chk({tag, "_we"}, 32'(ram_write_enable), 32'd0);
    chk({tag, "_addr"}, 32'(ram_addr), 32'd0);
    chk({tag, "_wdata"}, ram_write_data, 32'd0);
    chk({tag, "_ack0"}, 32'(ack0), 32'd0);
    chk({tag, "_ack1"}, 32'(ack1), 32'd0);
    chk({tag, "_rdata0"}, rdata0, 32'd0);
    chk({tag, "_rdata1"}, rdata1, 32'd0);
  endtask

  initial begin
    n_pass = 0; n_total = 0; cyc = 0;
    reset_n = 1'b0;
    clear_inputs();

    // Directed cycle table: inputs before an edge, expected outputs after it.
    vecs.push_back(mk(1,1,16'h10,32'hDEADBEEF, 0,0,16'h0,32'h0,  1,0,1,16'h10, 0,0, 32'h0,32'h0));
    vecs.push_back(mk(1,1,16'h10,32'hDEADBEEF, 0,0,16'h0,32'h0,  0,0,0,16'h10, 1,0, 32'h0,32'h0));
    vecs.push_back(mk(0,0,16'h0,32'h0, 1,0,16'h10,32'h0,         1,1,0,16'h10, 0,0, 32'h0,32'h0));
    vecs.push_back(mk(0,0,16'h0,32'h0, 1,0,16'h10,32'h0,         0,0,0,16'h10, 0,1, 32'h0,32'hDEADBEEF));
    vecs.push_back(mk(0,0,16'h0,32'h0, 0,0,16'h0,32'h0,          0,0,0,16'h10, 0,0, 32'h0,32'hDEADBEEF));
    vecs.push_back(mk(1,0,16'h10,32'h0, 1,1,16'h11,32'h55,       1,1,0,16'h10, 0,0, 32'h0,32'hDEADBEEF));
    vecs.push_back(mk(1,0,16'h10,32'h0, 1,1,16'h11,32'h55,       1,0,1,16'h11, 1,0, 32'hDEADBEEF,32'hDEADBEEF));
    vecs.push_back(mk(1,0,16'h10,32'h0, 1,1,16'h11,32'h55,       1,1,0,16'h10, 0,1, 32'hDEADBEEF,32'hDEADBEEF));
    vecs.push_back(mk(1,0,16'h10,32'h0, 1,1,16'h11,32'h55,       1,0,1,16'h11, 1,0, 32'hDEADBEEF,32'hDEADBEEF));
    vecs.push_back(mk(0,0,16'h10,32'h0, 1,1,16'h11,32'h55,       0,0,0,16'h11, 0,1, 32'hDEADBEEF,32'hDEADBEEF));
    vecs.push_back(mk(0,0,16'h0,32'h0, 0,0,16'h0,32'h0,          0,0,0,16'h11, 0,0, 32'hDEADBEEF,32'hDEADBEEF));
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0)
        vecs.push_back(mk(1,0,16'h11,32'h0, 0,0,16'h0,32'h0, 1,1,0,16'h11, 0,0,
                          (i == 0) ? 32'hDEADBEEF : 32'h55, 32'hDEADBEEF));
      else
        vecs.push_back(mk(1,0,16'h11,32'h0, 0,0,16'h0,32'h0, 0,0,0,16'h11, 1,0, 32'h55, 32'hDEADBEEF));
    end
    vecs.push_back(mk(0,0,16'h0,32'h0, 0,0,16'h0,32'h0,          0,0,0,16'h11, 0,0, 32'h55,32'hDEADBEEF));

    // Reset state.
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    reset_n = 1'b1;
    @(negedge clk);
    chk_all_zero("idle_after_reset");

    foreach (vecs[i]) begin
      req[0] = vecs[i].r0; we[0] = vecs[i].w0; addr[0] = vecs[i].a0; wdata[0] = vecs[i].d0;
      req[1] = vecs[i].r1; we[1] = vecs[i].w1; addr[1] = vecs[i].a1; wdata[1] = vecs[i].d1;
      @(negedge clk);
      chk($sformatf("v%0d_en", i), 32'(ram_enable), 32'(vecs[i].en));
      chk($sformatf("v%0d_re", i), 32'(ram_read_enable), 32'(vecs[i].re));
      chk($sformatf("v%0d_we", i), 32'(ram_write_enable), 32'(vecs[i].wr));
      chk($sformatf("v%0d_addr", i), 32'(ram_addr), 32'(vecs[i].ad));
      chk($sformatf("v%0d_ack0", i), 32'(ack0), 32'(vecs[i].k0));
      chk($sformatf("v%0d_ack1", i), 32'(ack1), 32'(vecs[i].k1));
      chk($sformatf("v%0d_rdata0", i), rdata0, vecs[i].q0);
      chk($sformatf("v%0d_rdata1", i), rdata1, vecs[i].q1);
    end

    // Reset asserted in the middle of a write ACCESS.
    clear_inputs();
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 16'h20; wdata[0] = 32'hCAFEF00D;
    @(negedge clk);
    chk("midrst_access_en", 32'(ram_enable), 32'd1);
    chk("midrst_access_we", 32'(ram_write_enable), 32'd1);
    #1 reset_n = 1'b0;
    #1 chk_all_zero("midrst_async");
    clear_inputs();
    @(negedge clk);
    chk("midrst_no_ack0", 32'(ack0), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("midrst_release_ack0", 32'(ack0), 32'd0);
    chk("midrst_release_en", 32'(ram_enable), 32'd0);

    // Write/read race on one address right after reset: the fetch port wins the tie.
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 16'h30; wdata[0] = 32'h1;
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = 16'h30; wdata[1] = 32'h0;
    @(negedge clk);
    chk("race_first_we", 32'(ram_write_enable), 32'd1);
    chk("race_first_addr", 32'(ram_addr), 32'h30);
    chk("race_first_wdata", ram_write_data, 32'h1);
    @(negedge clk);
    chk("race_ack0", 32'(ack0), 32'd1);
    chk("race_second_re", 32'(ram_read_enable), 32'd1);
    chk("race_second_ack1", 32'(ack1), 32'd0);
    req[0] = 1'b0;
    @(negedge clk);
    chk("race_ack1", 32'(ack1), 32'd1);
    chk("race_rdata1", rdata1, 32'h1);
    chk("race_ack0_low", 32'(ack0), 32'd0);
    chk("race_idle_en", 32'(ram_enable), 32'd0);
    clear_inputs();
    @(negedge clk);

    // Random traffic: acks never overlap, so ack order is the RAM's service order.
    begin
      logic act [2];
      int   iss [2];
      act[0] = 1'b0; act[1] = 1'b0; iss[0] = 0; iss[1] = 0;
      for (int c = 0; c < 400; c++) begin
        @(negedge clk);
        chk("ack_exclusive", 32'(ack0 & ack1), 32'd0);
        chk("rw_exclusive", 32'(ram_read_enable & ram_write_enable), 32'd0);
        for (int p = 0; p < 2; p++) begin
          logic          a;
          logic [DW-1:0] rd, exp;
          int            lat, key;
          a   = (p == 0) ? ack0 : ack1;
          rd  = (p == 0) ? rdata0 : rdata1;
          key = int'(addr[p]);
          if (act[p]) begin
            lat = cyc - iss[p];
            if (a) begin
              chk($sformatf("p%0d_latency_%0d", p, lat), 32'(lat >= 1 && lat <= 2), 32'd1);
              if (we[p]) begin
                ref_mem[key] = wdata[p];
              end else begin
                exp = ref_mem.exists(key) ? ref_mem[key] : 32'h0;
                chk($sformatf("p%0d_rdata_a%0h", p, key), rd, exp);
              end
              act[p] = 1'b0; req[p] = 1'b0;
            end else if (lat > 3) begin
              chk($sformatf("p%0d_ack_timeout", p), 32'(a), 32'd1);
              act[p] = 1'b0; req[p] = 1'b0;
            end
          end else begin
            chk($sformatf("p%0d_spurious_ack", p), 32'(a), 32'd0);
          end
          if (!act[p] && $urandom_range(3, 0) != 0) begin
            act[p]   = 1'b1;
            req[p]   = 1'b1;
            we[p]    = 1'($urandom_range(1, 0));
            addr[p]  = 16'h40 + 16'($urandom_range(7, 0));
            wdata[p] = $urandom;
            iss[p]   = cyc + 1;
          end
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ceyloniac_ram_arbiter.md
Name: ceyloniac_ram_arbiter

Overview:
- Two-port round-robin arbiter and sequencer that shares the single-port ceyloniac_sync_ram between requester 0 (instruction fetch) and requester 1 (data/memory stage).
- Latches the winning request, drives the RAM control, address and data lines from registers for exactly one ACCESS cycle, captures read data, then returns a one-cycle ack with the result.
- Sits between the core pipeline and the RAM instance.

Parameters:
- RAM_DATA_WIDTH, 32, data width; must match the RAM.
- RAM_ADDR_WIDTH, 16, address width; must match the RAM.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- req0  in  1  requester 0 access request; hold high until ack0.
- addr0  in  RAM_ADDR_WIDTH  requester 0 address; stable while req0 is high.
- we0  in  1  requester 0 write (1) or read (0).
- wdata0  in  RAM_DATA_WIDTH  requester 0 write data.
- ack0  out  1  one-cycle completion pulse for requester 0.
- rdata0  out  RAM_DATA_WIDTH  requester 0 read result; valid while ack0 is high.
- req1, addr1, we1, wdata1, ack1, rdata1: same as above for requester 1.
- ram_enable  out  1  to RAM ram_enable.
- ram_read_enable  out  1  to RAM ram_read_enable.
- ram_write_enable  out  1  to RAM ram_write_enable.
- ram_addr  out  RAM_ADDR_WIDTH  to RAM ram_addr.
- ram_write_data  out  RAM_DATA_WIDTH  to RAM ram_write_data.
- ram_read_data  in  RAM_DATA_WIDTH  from RAM; combinational on ram_addr while enabled.

Behaviour:
- Reset (async on reset_n low):
  - state=IDLE; every output is 0; rdata0/rdata1 are 0.
  - last_grant=1, so requester 0 wins the first tie.
- States: IDLE, ACCESS.
- IDLE:
  - No req at a rising edge: stay in IDLE.
  - Any req at a rising edge: pick the winner, latch its addr/we/wdata into the RAM output registers, set ram_enable=1, ram_read_enable=~we, ram_write_enable=we, set last_grant=winner, go to ACCESS.
- Arbitration:
  - Only one req high: that requester wins.
  - Both high: the requester != last_grant wins (strict alternation).
- ACCESS lasts exactly one cycle. At its closing edge:
  - The RAM performs the write, if any.
  - On a read, ram_read_data is captured into rdata of the served port. The other port's rdata holds its value.
  - ack of the served port is set for the next cycle.
  - Next-request decision at the same edge:
    - The served requester is excluded, because its req is still high until it sees the ack.
    - If the other req is high: latch it, stay in ACCESS, update last_grant.
    - Otherwise: go to IDLE and clear ram_enable/ram_read_enable/ram_write_enable. ram_addr and ram_write_data hold their values.
- ack pulses are exactly one cycle and never both high in the same cycle.
- Latency: req sampled at edge N → ACCESS during cycle N+1 → ack and rdata valid in cycle N+2.
- Throughput:
  - A single requester gets one access per 2 cycles.
  - Alternating requesters get one access per cycle.
- Requester protocol:
  - Deassert req in the ack cycle, or keep it high to request again; the arbiter re-samples it at the next edge.
  - Changing addr/we/wdata while req is high before ack is a protocol violation; the latched values are used.
- Write completion: the ack for a write follows the RAM write edge, so a read issued after that ack returns the new data.
- Reset mid-ACCESS:
  - Immediate return to IDLE with all outputs 0.
  - The write may or may not have landed.
  - No ack is issued.
- ram_read_enable and ram_write_enable are never both high.

Decomposition:
- Shared package (ceyloniac_mem_pkg): state encoding (IDLE=1'b0, ACCESS=1'b1), requester ID constants (REQ_FETCH=0, REQ_DATA=1), default widths.
- One natural sub-module: ceyloniac_rr_arb2, the 2-way round-robin grant logic holding last_grant. Everything else stays in the top level.

Test Plan:
- Reset, then req0=1 addr0=16'h0010 we0=1 wdata0=32'hDEADBEEF → ram_write_enable=1 in cycle 1; ack0 pulses in cycle 2; ack1 stays 0.
- req1 read addr1=16'h0010 → ack1 two cycles later with rdata1=32'hDEADBEEF; ram_read_enable=1 only during ACCESS.
- req0 and req1 both held high from the same edge → grants 0,1,0,1 on consecutive cycles; acks alternate every cycle; never both high.
- req0 alone held high for 4 accesses → ack0 every 2nd cycle; ram_enable toggles 1,0,1,0.
- reset_n low during ACCESS of a write to 16'h0020 → all outputs 0 immediately; no ack; next req0 after release is served normally.
- Two-requester write/read race: req0 writes 32'h1 to 16'h0030 while req1 reads 16'h0030 (last_grant=1) → write served first; rdata1=32'h1.
